conv_row_sched: RTL

//  Sequencer for the row-parallel conv PE array. On start_conv it fetches K_ROWS kernel

---
 rtl/conv_row_sched.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/conv_row_sched.sv
// ============================================================================
//  Module   : conv_row_sched
//  Purpose  : Row sequencer for the row-parallel conv PE array: loads kernel
//             rows, streams feature rows, triggers PE passes and output writes.
//  Options  : PERF_CNT_EN - builds the busy-cycle counter on perf_cycles.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_row_sched #(
    parameter int IMG_ROWS = 64,
    parameter int K_ROWS   = 4,
    parameter int CI_W     = 9
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_conv,
    input  logic [CI_W-1:0] cfg_ci,
    input  logic [1:0]      cfg_co,
    output logic            busy,
    output logic            end_conv,
    output logic            w_rd_en,
    output logic [1:0]      w_rd_addr,
    input  logic            w_rd_valid,
    output logic            i_rd_en,
    output logic [5:0]      i_rd_addr,
    input  logic            i_rd_valid,
    output logic            pe_start,
    output logic [CI_W-1:0] pe_ci,
    input  logic            pe_done,
    output logic            o_wr_en,
    output logic [5:0]      o_wr_row,
    output logic [1:0]      o_wr_pass,
    output logic [31:0]     perf_cycles
);

    localparam logic [2:0] c_S_IDLE    = 3'd0;
    localparam logic [2:0] c_S_LOAD_W  = 3'd1;
    localparam logic [2:0] c_S_LOAD_I  = 3'd2;
    localparam logic [2:0] c_S_COMPUTE = 3'd3;
    localparam logic [2:0] c_S_WRITE   = 3'd4;
    localparam logic [2:0] c_S_DONE    = 3'd5;

    localparam logic [5:0] c_LAST_ROW  = 6'(IMG_ROWS - 1);
    localparam logic [5:0] c_OUT_LAG   = 6'(K_ROWS - 1);
    localparam logic [1:0] c_LAST_KROW = 2'(K_ROWS - 1);

    logic [2:0]      r_state;
    logic [2:0]      w_state_nxt;
    logic [1:0]      r_krow;
    logic [5:0]      r_row;
    logic [1:0]      r_pass;
    logic [CI_W-1:0] r_ci;
    logic [1:0]      r_co;
    logic            r_wgap;
    logic            r_pe_start;

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        end_conv    = 1'b0;
        w_rd_en     = 1'b0;
        i_rd_en     = 1'b0;
        o_wr_en     = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                if (start_conv)
                    w_state_nxt = (cfg_ci == '0) ? c_S_DONE : c_S_LOAD_W;
            end
            c_S_LOAD_W: begin
                busy = 1'b1;
                // One idle cycle after each returned row keeps a single read in flight.
                w_rd_en = !r_wgap;
                if (!r_wgap && w_rd_valid && r_krow == c_LAST_KROW)
                    w_state_nxt = c_S_LOAD_I;
            end
            c_S_LOAD_I: begin
                busy    = 1'b1;
                i_rd_en = 1'b1;
                if (i_rd_valid)
                    w_state_nxt = c_S_COMPUTE;
            end
            c_S_COMPUTE: begin
                busy = 1'b1;
                if (pe_done)
                    w_state_nxt = (r_row >= c_OUT_LAG) ? c_S_WRITE : c_S_LOAD_I;
            end
            c_S_WRITE: begin
                busy    = 1'b1;
                o_wr_en = 1'b1;
                if (r_row == c_LAST_ROW)
                    w_state_nxt = (r_pass == r_co) ? c_S_DONE : c_S_LOAD_W;
                else
                    w_state_nxt = c_S_LOAD_I;
            end
            c_S_DONE: begin
                end_conv    = 1'b1;
                w_state_nxt = c_S_IDLE;
            end
            default: w_state_nxt = c_S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_S_IDLE;
            r_krow     <= '0;
            r_row      <= '0;
            r_pass     <= '0;
            r_ci       <= '0;
            r_co       <= '0;
            r_wgap     <= 1'b0;
            r_pe_start <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pe_start <= (r_state == c_S_LOAD_I) && i_rd_valid;
            r_wgap     <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    if (start_conv) begin
                        r_ci   <= cfg_ci;
                        r_co   <= cfg_co;
                        r_row  <= '0;
                        r_pass <= '0;
                        r_krow <= '0;
                    end
                end
                c_S_LOAD_W: begin
                    if (!r_wgap && w_rd_valid) begin
                        r_wgap <= 1'b1;
                        r_krow <= (r_krow == c_LAST_KROW) ? 2'd0 : r_krow + 2'd1;
                    end
                end
                c_S_COMPUTE: begin
                    if (pe_done && r_row < c_OUT_LAG)
                        r_row <= r_row + 6'd1;
                end
                c_S_WRITE: begin
                    if (r_row == c_LAST_ROW) begin
                        r_row  <= '0;
                        r_pass <= r_pass + 2'd1;
                    end else begin
                        r_row <= r_row + 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_rd_addr = r_krow;
    assign i_rd_addr = r_row;
    assign pe_start  = r_pe_start;
    assign pe_ci     = r_ci;
    assign o_wr_row  = o_wr_en ? (r_row - c_OUT_LAG) : 6'd0;
    assign o_wr_pass = o_wr_en ? r_pass : 2'd0;

`ifdef PERF_CNT_EN
    logic [31:0] r_perf;

    always_ff @(posedge clk) begin
        if (rst)
            r_perf <= '0;
        else if (r_state == c_S_IDLE && start_conv)
            r_perf <= '0;
        else if (busy)
            r_perf <= r_perf + 32'd1;
    end

    assign perf_cycles = r_perf;
`else
    assign perf_cycles = 32'd0;
`endif

endmodule

`default_nettype wire
